// File: rtl/laser_pulse_monitor.sv
// laser_pulse_monitor
//   Receive-side checker for the laser enable line X. Each on-pulse must be
//   exactly PULSE_LEN high samples long, and it must be followed by at least
//   MIN_GAP low samples. The first low sample counts towards the gap.
//   Every valid exposure produces a one-cycle Ok pulse and increments Shots,
//   which saturates at all-ones.
//   A short pulse, a long pulse or a short gap latches a sticky fault. The
//   fault is held until Clr.
//
// Optional feature macro: LASER_MON_INHIBIT_EN
//   When defined, Inhibit is high while the state is GAP, FAULT or SKIP.
//   When undefined, Inhibit is tied low and no extra logic is generated.
//
// Ports
//   Clk        in   1       system clock, rising edge
//   Rst        in   1       asynchronous active-low reset
//   X          in   1       laser on/off line, synchronous to Clk
//   Clr        in   1       synchronous clear of Fault, FaultCode, Shots
//   Ok         out  1       one-cycle pulse after a valid exposure
//   Fault      out  1       sticky fault flag
//   FaultCode  out  2       00 none, 01 short pulse, 10 long pulse, 11 short gap
//   Shots      out  SHOT_W  saturating count of valid exposures
//   Busy       out  1       high while in state ON
//   Inhibit    out  1       start-button interlock (see macro above)

module laser_pulse_monitor #(
    parameter int PULSE_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int MIN_GAP   = 4,
    parameter int SHOT_W    = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              X,
    input  logic              Clr,
    output logic              Ok,
    output logic              Fault,
    output logic [1:0]        FaultCode,
    output logic [SHOT_W-1:0] Shots,
    output logic              Busy,
    output logic              Inhibit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_GAP,
        S_FAULT,
        S_SKIP
    } state_t;

    localparam logic [CNT_W-1:0] L_PULSE    = CNT_W'(PULSE_LEN);
    // The gap is complete on the edge where the count would reach MIN_GAP.
    localparam logic [CNT_W-1:0] L_GAP_LAST = CNT_W'(MIN_GAP - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  w_nextLen;
    logic              w_validPulse;
    logic              w_faultSet;
    logic [1:0]        w_faultCodeSet;

    logic              r_ok;
    logic              r_fault;
    logic [1:0]        r_faultCode;
    logic [SHOT_W-1:0] r_shots;
    logic              r_busy;

    logic              w_okNext;
    logic              w_faultNext;
    logic [1:0]        w_faultCodeNext;
    logic [SHOT_W-1:0] w_shotsNext;
    logic              w_busyNext;

    // State register and pulse/gap length counter
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
        end else begin
            r_state <= w_nextState;
            r_len   <= w_nextLen;
        end
    end

    // Next-state logic. Clr overrides any measurement on the same edge,
    // so a fault detected on that edge is never latched.
    always_comb begin
        w_nextState    = r_state;
        w_nextLen      = r_len;
        w_validPulse   = 1'b0;
        w_faultSet     = 1'b0;
        w_faultCodeSet = 2'b00;
        if (Clr) begin
            w_nextState = X ? S_SKIP : S_IDLE;
            w_nextLen   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (X) begin
                        w_nextState = S_ON;
                        w_nextLen   = CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (X) begin
                        if (r_len >= L_PULSE) begin
                            w_nextState    = S_FAULT;
                            w_nextLen      = '0;
                            w_faultSet     = 1'b1;
                            w_faultCodeSet = 2'b10;
                        end else begin
                            w_nextLen = r_len + CNT_W'(1);
                        end
                    end else if (r_len == L_PULSE) begin
                        w_nextState  = S_GAP;
                        w_nextLen    = CNT_W'(1);
                        w_validPulse = 1'b1;
                    end else begin
                        w_nextState    = S_FAULT;
                        w_nextLen      = '0;
                        w_faultSet     = 1'b1;
                        w_faultCodeSet = 2'b01;
                    end
                end
                S_GAP: begin
                    if (X) begin
                        w_nextState    = S_FAULT;
                        w_nextLen      = '0;
                        w_faultSet     = 1'b1;
                        w_faultCodeSet = 2'b11;
                    end else if (r_len >= L_GAP_LAST) begin
                        w_nextState = S_IDLE;
                        w_nextLen   = '0;
                    end else begin
                        w_nextLen = r_len + CNT_W'(1);
                    end
                end
                S_FAULT: begin
                    w_nextState = S_FAULT;
                end
                S_SKIP: begin
                    if (!X) begin
                        w_nextState = S_IDLE;
                    end
                end
                default: begin
                    w_nextState = S_IDLE;
                    w_nextLen   = '0;
                end
            endcase
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_okNext        = w_validPulse;
        w_busyNext      = (w_nextState == S_ON);
        w_faultNext     = r_fault;
        w_faultCodeNext = r_faultCode;
        w_shotsNext     = r_shots;
        if (Clr) begin
            w_faultNext     = 1'b0;
            w_faultCodeNext = 2'b00;
            w_shotsNext     = '0;
        end else begin
            if (w_faultSet) begin
                w_faultNext     = 1'b1;
                w_faultCodeNext = w_faultCodeSet;
            end
            if (w_validPulse && (r_shots != {SHOT_W{1'b1}})) begin
                w_shotsNext = r_shots + SHOT_W'(1);
            end
        end
    end

    // Output registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_ok        <= 1'b0;
            r_fault     <= 1'b0;
            r_faultCode <= 2'b00;
            r_shots     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_ok        <= w_okNext;
            r_fault     <= w_faultNext;
            r_faultCode <= w_faultCodeNext;
            r_shots     <= w_shotsNext;
            r_busy      <= w_busyNext;
        end
    end

    assign Ok        = r_ok;
    assign Fault     = r_fault;
    assign FaultCode = r_faultCode;
    assign Shots     = r_shots;
    assign Busy      = r_busy;

`ifdef LASER_MON_INHIBIT_EN
    logic r_inhibit;

    // Interlock follows the state being entered, so it is aligned with Busy
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_inhibit <= 1'b0;
        end else begin
            r_inhibit <= (w_nextState == S_GAP) || (w_nextState == S_FAULT) ||
                         (w_nextState == S_SKIP);
        end
    end

    assign Inhibit = r_inhibit;
`else
    assign Inhibit = 1'b0;
`endif

endmodule

// File: tb/tb_laser_pulse_monitor.sv
// tb_laser_pulse_monitor
//   Self-checking bench for laser_pulse_monitor. It uses one default instance
//   and one instance with SHOT_W=2 for the saturation case. Expected Ok events
//   (with the Shots value that accompanies them) and expected fault codes are
//   queued when stimulus is issued. A monitor pops and compares them whenever
//   the DUT raises Ok or Fault.

module tb_laser_pulse_monitor;

`ifdef LASER_MON_INHIBIT_EN
    localparam logic INH_EN = 1'b1;
`else
    localparam logic INH_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst;
    logic       X;
    logic       Clr;
    logic       X2;
    logic       Clr2;

    logic       Ok;
    logic       Fault;
    logic [1:0] FaultCode;
    logic [7:0] Shots;
    logic       Busy;
    logic       Inhibit;

    logic       Ok2;
    logic       Fault2;
    logic [1:0] FaultCode2;
    logic [1:0] Shots2;
    logic       Busy2;
    logic       Inhibit2;

    int total = 0;
    int bad   = 0;

    logic [7:0] okQ[$];
    logic [1:0] ok2Q[$];
    logic [1:0] faultQ[$];
    logic       prevFault;
    int         busyCnt;

    always #5 Clk = ~Clk;

    laser_pulse_monitor dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .X         (X),
        .Clr       (Clr),
        .Ok        (Ok),
        .Fault     (Fault),
        .FaultCode (FaultCode),
        .Shots     (Shots),
        .Busy      (Busy),
        .Inhibit   (Inhibit)
    );

    laser_pulse_monitor #(.SHOT_W(2)) dut2 (
        .Clk       (Clk),
        .Rst       (Rst),
        .X         (X2),
        .Clr       (Clr2),
        .Ok        (Ok2),
        .Fault     (Fault2),
        .FaultCode (FaultCode2),
        .Shots     (Shots2),
        .Busy      (Busy2),
        .Inhibit   (Inhibit2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Drive one pulse of hi high samples then lo low samples on one instance
    task automatic applyStimulus(input logic sel, input int hi, input int lo);
        if (sel) X2 = 1'b1; else X = 1'b1;
        tick(hi);
        if (sel) X2 = 1'b0; else X = 1'b0;
        tick(lo);
    endtask

    initial begin
        Rst  = 1'b0;
        X    = 1'b0;
        Clr  = 1'b0;
        X2   = 1'b0;
        Clr2 = 1'b0;
        prevFault = 1'b0;

        fork
            // Scoreboard monitor: samples on the falling edge
            forever begin
                @(negedge Clk);
                if (Ok === 1'b1) begin
                    if (okQ.size() == 0) checkOutput("unexpectedOk", 32'(Ok), 0);
                    else checkOutput("okShots", 32'(Shots), 32'(okQ.pop_front()));
                end
                if (Ok2 === 1'b1) begin
                    if (ok2Q.size() == 0) checkOutput("unexpectedOk2", 32'(Ok2), 0);
                    else checkOutput("ok2Shots", 32'(Shots2), 32'(ok2Q.pop_front()));
                end
                if (Fault === 1'b1 && prevFault == 1'b0) begin
                    if (faultQ.size() == 0) checkOutput("unexpectedFault", 32'(Fault), 0);
                    else checkOutput("faultCode", 32'(FaultCode), 32'(faultQ.pop_front()));
                end
                prevFault = Fault;
            end
        join_none

        // Reset state
        tick(3);
        checkOutput("rstOk", 32'(Ok), 0);
        checkOutput("rstFault", 32'(Fault), 0);
        checkOutput("rstShots", 32'(Shots), 0);
        checkOutput("rstBusy", 32'(Busy), 0);
        checkOutput("rstInhibit", 32'(Inhibit), 0);
        Rst = 1'b1;
        tick(2);

        // 1: reset asserted mid-pulse clears outputs at once
        X = 1'b1;
        tick(8);
        checkOutput("t1BusyBefore", 32'(Busy), 1);
        #2;
        Rst = 1'b0;
        #1;
        checkOutput("t1BusyRst", 32'(Busy), 0);
        checkOutput("t1FaultRst", 32'(Fault), 0);
        X = 1'b0;
        tick(1);
        Rst = 1'b1;
        tick(2);
        checkOutput("t1Fault", 32'(Fault), 0);
        checkOutput("t1Busy", 32'(Busy), 0);

        // 2: clean 16-high pulse, Busy high for exactly 16 cycles
        okQ.push_back(8'd1);
        busyCnt = 0;
        X = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (Busy) busyCnt++;
        end
        X = 1'b0;
        tick(1);
        checkOutput("t2BusyLow", 32'(Busy), 0);
        checkOutput("t2InhibitGap", 32'(Inhibit), 32'(INH_EN));
        tick(3);
        checkOutput("t2BusyCnt", 32'(busyCnt), 16);
        checkOutput("t2Shots", 32'(Shots), 1);
        checkOutput("t2Fault", 32'(Fault), 0);
        checkOutput("t2InhibitIdle", 32'(Inhibit), 0);

        // 3: short pulse, Shots unchanged, then Clr with X low
        faultQ.push_back(2'b01);
        applyStimulus(1'b0, 10, 2);
        checkOutput("t3Fault", 32'(Fault), 1);
        checkOutput("t3Code", 32'(FaultCode), 1);
        checkOutput("t3Shots", 32'(Shots), 1);
        Clr = 1'b1;
        tick(1);
        Clr = 1'b0;
        checkOutput("t3ClrFault", 32'(Fault), 0);
        checkOutput("t3ClrCode", 32'(FaultCode), 0);
        checkOutput("t3ClrShots", 32'(Shots), 0);

        // 4: long pulse, then Clr while high goes to SKIP
        faultQ.push_back(2'b10);
        X = 1'b1;
        tick(16);
        checkOutput("t4Fault16", 32'(Fault), 0);
        checkOutput("t4Busy16", 32'(Busy), 1);
        tick(1);
        checkOutput("t4Fault17", 32'(Fault), 1);
        checkOutput("t4Code", 32'(FaultCode), 2);
        checkOutput("t4BusyFault", 32'(Busy), 0);
        tick(3);
        Clr = 1'b1;
        tick(1);
        Clr = 1'b0;
        checkOutput("t4ClrFault", 32'(Fault), 0);
        checkOutput("t4ClrCode", 32'(FaultCode), 0);
        checkOutput("t4InhibitSkip", 32'(Inhibit), 32'(INH_EN));
        tick(3);
        checkOutput("t4SkipBusy", 32'(Busy), 0);
        X = 1'b0;
        tick(1);
        checkOutput("t4InhibitIdle", 32'(Inhibit), 0);
        okQ.push_back(8'd1);
        applyStimulus(1'b0, 16, 4);
        checkOutput("t4Shots", 32'(Shots), 1);
        checkOutput("t4FaultAfter", 32'(Fault), 0);

        // 5: short gap faults; a 4-cycle gap is clean
        Clr = 1'b1;
        tick(1);
        Clr = 1'b0;
        okQ.push_back(8'd1);
        applyStimulus(1'b0, 16, 2);
        faultQ.push_back(2'b11);
        applyStimulus(1'b0, 16, 2);
        checkOutput("t5Shots", 32'(Shots), 1);
        checkOutput("t5Code", 32'(FaultCode), 3);
        Clr = 1'b1;
        tick(1);
        Clr = 1'b0;
        okQ.push_back(8'd1);
        applyStimulus(1'b0, 16, 4);
        okQ.push_back(8'd2);
        applyStimulus(1'b0, 16, 4);
        checkOutput("t5Shots2", 32'(Shots), 2);
        checkOutput("t5Fault", 32'(Fault), 0);

        // 6: SHOT_W=2 saturation, then Clr while the 5th Ok is high
        ok2Q.push_back(2'd1);
        applyStimulus(1'b1, 16, 4);
        ok2Q.push_back(2'd2);
        applyStimulus(1'b1, 16, 4);
        ok2Q.push_back(2'd3);
        applyStimulus(1'b1, 16, 4);
        ok2Q.push_back(2'd3);
        applyStimulus(1'b1, 16, 4);
        checkOutput("t6Sat", 32'(Shots2), 3);
        ok2Q.push_back(2'd3);
        applyStimulus(1'b1, 16, 1);
        Clr2 = 1'b1;
        tick(1);
        Clr2 = 1'b0;
        checkOutput("t6ClrShots", 32'(Shots2), 0);
        checkOutput("t6OkLow", 32'(Ok2), 0);
        tick(4);
        checkOutput("t6Fault2", 32'(Fault2), 0);
        checkOutput("t6Code2", 32'(FaultCode2), 0);
        checkOutput("t6Busy2", 32'(Busy2), 0);
        checkOutput("t6Inhibit2", 32'(Inhibit2), 0);

        // Every expected event must have been observed
        checkOutput("okQLeft", 32'(okQ.size()), 0);
        checkOutput("ok2QLeft", 32'(ok2Q.size()), 0);
        checkOutput("faultQLeft", 32'(faultQ.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
